fakeram45_64x21_arb: RTL and testbench
======================================

Name: fakeram45_64x21_arb

Overview:
Two-requester arbiter and sequencer for one fakeram45_64x21 single-port SRAM macro (64 words x 21 bits, 1-cycle registered read, bit-masked write).
- Shares the macro between two independent clients (e.g. a tag lookup port and a fill/update port) using round-robin grant.
- Returns read data with a valid strobe.
- Never presents X or a spurious enable to the macro.
- Sits directly between the clients and the macro instance.

Parameters:
BITS, 21, data/mask width
WORD_DEPTH, 64, number of words
ADDR_WIDTH, 6, address width (log2 WORD_DEPTH)

Ports:
clk  input  1  clock; single clock domain, shared with the macro
rst_l  input  1  asynchronous active-low reset
pN_req  input  1  client N (N=0,1) request; held with fields stable until granted
pN_we  input  1  client N: 1=write, 0=read
pN_addr  input  ADDR_WIDTH  client N address
pN_wd  input  BITS  client N write data
pN_wmask  input  BITS  client N write bit mask (1=write bit)
pN_gnt  output  1  client N request accepted this cycle
pN_rvalid  output  1  client N read data valid
pN_rdata  output  BITS  client N read data
ram_ce  output  1  macro chip enable
ram_we  output  1  macro write enable
ram_addr  output  ADDR_WIDTH  macro address
ram_wd  output  BITS  macro write data
ram_wmask  output  BITS  macro write mask
ram_rd  input  BITS  macro read data (rd_out)
init_done  output  1  block ready to accept requests

Behaviour:
- Arbitration is combinational within a cycle. pN_gnt = pN_req & selected & init_done; at most one gnt per cycle.
- Single requester always wins. When both request, the winner is the port not granted most recently.
- Register last_gnt is updated on every grant. Reset value is 1, so p0 wins the first contention.
- Worst-case wait is one cycle.
- Macro drive:
  - ram_ce = p0_gnt | p1_gnt.
  - ram_we/addr/wd/wmask are muxed from the winner.
  - When ram_ce=0, all of them are driven 0. Never X, never floating.
- Read return:
  - Read granted in cycle T -> pN_rvalid=1 in cycle T+1, with pN_rdata = ram_rd.
  - rvalid is a registered copy of (gnt & ~we) per port.
  - pN_rdata is 0 whenever pN_rvalid=0, so the macro's X output on idle cycles is masked.
- Write: a grant with we=1 produces no rvalid. Mask semantics are the macro's: new = (wd & wmask) | (old & ~wmask).
- Back-to-back: a grant is possible every cycle. A write to addr A at T followed by a read of A at T+1 returns the new data at T+2. Reads on alternating ports pipeline with no bubble.
- Reset:
  - All outputs are 0 except init_done (see Optional Feature).
  - last_gnt=1; rvalid flops=0.
  - Reset asserted mid-operation drops a pending rvalid; no response is produced after reset.
- Clients must not change fields while req=1 and gnt=0. Violation is undefined; the bench flags it.

Optional Feature:
Macro: FAKERAM45_64X21_ARB_INIT_EN
- Defined: a 2-state FSM INIT -> RUN.
  - Reset enters INIT with init counter=0 and init_done=0.
  - In INIT each cycle: ram_ce=1, ram_we=1, ram_addr=counter, ram_wd=0, ram_wmask=all ones; both gnt=0; counter increments.
  - After writing address WORD_DEPTH-1 (64 cycles), moves to RUN with init_done=1.
  - Reset asserted during INIT restarts at address 0.
- Undefined: no FSM, no counter; init_done is constant 1 and requests are serviced in the first cycle after reset release.

Test Plan:
- p0 write addr 5, wd=0x1ABCD, wmask=0x1FFFFF; then p0 read addr 5 -> gnt each cycle; p0_rvalid one cycle after the read grant with p0_rdata=0x1ABCD; p1_rvalid stays 0.
- Masked write: addr 9 holds 0x000FF; write wd=0x1FF00, wmask=0x00F00; read addr 9 -> 0x00FFF.
- p0 and p1 request reads continuously from reset (after init) -> grants alternate p0,p1,p0,p1; each rvalid asserted on its own port only, 1 cycle after its grant.
- Idle cycles -> ram_ce=0, ram_we=0, ram_addr=0, ram_wd=0, ram_wmask=0; pN_rdata=0 (no X on any output).
- Read granted at T, rst_l low at T+0.5 -> pN_rvalid=0 at T+1; after release last_gnt=1, so under contention p0 is granted first.
- With FAKERAM45_64X21_ARB_INIT_EN defined, hold p0_req from reset:
  - Expect 64 init writes (addr 0..63, data 0), no grant, and init_done=0 during init.
  - Grant in cycle 65; reading any address returns 0.
  - Reset pulsed at init addr 30 restarts init at addr 0.

Source files
------------

// File: rtl/fakeram45_64x21_arb.sv
// Round-robin two-client arbiter/sequencer in front of one fakeram45_64x21 SRAM macro.
// Define FAKERAM45_64X21_ARB_INIT_EN to zero-fill the macro after reset before serving clients.
module fakeram45_64x21_arb #(
  parameter int BITS       = 21,
  parameter int WORD_DEPTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [BITS-1:0]       p0_wd,
  input  logic [BITS-1:0]       p0_wmask,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [BITS-1:0]       p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [BITS-1:0]       p1_wd,
  input  logic [BITS-1:0]       p1_wmask,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [BITS-1:0]       p1_rdata,
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BITS-1:0]       ram_wd,
  output logic [BITS-1:0]       ram_wmask,
  input  logic [BITS-1:0]       ram_rd,
  output logic                  init_done
);

  if (WORD_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("WORD_DEPTH does not fit in ADDR_WIDTH address bits");
  end

  logic                  last_gnt_q, last_gnt_d;
  logic                  p0_rvalid_q, p0_rvalid_d;
  logic                  p1_rvalid_q, p1_rvalid_d;
  logic                  run_en;
  logic                  init_wr;
  logic [ADDR_WIDTH-1:0] init_addr;

`ifdef FAKERAM45_64X21_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST_ADDR) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Fill writes are held off while reset is asserted so the macro sees no enable.
  assign init_wr   = rst_l & (state_q == ST_INIT);
  assign init_addr = init_cnt_q;
  assign init_done = init_done_q;
`else
  assign init_wr   = 1'b0;
  assign init_addr = '0;
  assign init_done = 1'b1;
`endif

  assign run_en = rst_l & init_done;

  // last_gnt_q=1 means p1 won most recently, so p0 takes the next contention.
  always_comb begin
    p0_gnt      = p0_req & run_en & (~p1_req | last_gnt_q);
    p1_gnt      = p1_req & run_en & (~p0_req | ~last_gnt_q);
    last_gnt_d  = last_gnt_q;
    if (p0_gnt) begin
      last_gnt_d = 1'b0;
    end else if (p1_gnt) begin
      last_gnt_d = 1'b1;
    end
    p0_rvalid_d = p0_gnt & ~p0_we;
    p1_rvalid_d = p1_gnt & ~p1_we;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      last_gnt_q  <= 1'b1;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
    end
  end

  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wd    = '0;
    ram_wmask = '0;
    if (init_wr) begin
      ram_ce    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = init_addr;
      ram_wmask = '1;
    end else if (p0_gnt) begin
      ram_ce    = 1'b1;
      ram_we    = p0_we;
      ram_addr  = p0_addr;
      ram_wd    = p0_wd;
      ram_wmask = p0_wmask;
    end else if (p1_gnt) begin
      ram_ce    = 1'b1;
      ram_we    = p1_we;
      ram_addr  = p1_addr;
      ram_wd    = p1_wd;
      ram_wmask = p1_wmask;
    end
  end

  // Macro output is undefined on cycles it was not read, so mask it outside rvalid.
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rvalid_q ? ram_rd : '0;
  assign p1_rdata  = p1_rvalid_q ? ram_rd : '0;

endmodule

// File: tb/tb_fakeram45_64x21_arb.sv
// Bench for fakeram45_64x21_arb: behavioural macro model plus read-return scoreboard.
module tb_fakeram45_64x21_arb;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [5:0]  p0_addr, p1_addr;
  logic [20:0] p0_wd, p0_wmask, p1_wd, p1_wmask;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [20:0] p0_rdata, p1_rdata;
  logic        ram_ce, ram_we;
  logic [5:0]  ram_addr;
  logic [20:0] ram_wd, ram_wmask, ram_rd;
  logic        init_done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int cyc       = 0;

  typedef struct {
    logic [20:0] data;
    int          due;
  } rd_item_t;

  rd_item_t    q0[$];
  rd_item_t    q1[$];
  logic [20:0] ref_mem [64];
  logic [20:0] mem [64];
  bit          loaded = 1'b0;

  fakeram45_64x21_arb dut (
    .clk(clk), .rst_l(rst_l),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wd(p0_wd), .p0_wmask(p0_wmask),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wd(p1_wd), .p1_wmask(p1_wmask),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd),
    .ram_wmask(ram_wmask), .ram_rd(ram_rd), .init_done(init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [20:0] pat(input int i);
    logic [31:0] t;
    t = (i * 32'h0000B3D7) ^ 32'h00005A5A;
    return t[20:0];
  endfunction

  // Macro model: masked write, registered read, garbage on non-read cycles.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
      loaded <= 1'b1;
    end else if (ram_ce && ram_we) begin
      mem[ram_addr] <= (ram_wd & ram_wmask) | (mem[ram_addr] & ~ram_wmask);
    end
    ram_rd <= (ram_ce && !ram_we) ? mem[ram_addr] : 21'h0DEAD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop(input int p);
    if (p == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic mon(input int p);
    logic        rv;
    logic [20:0] rd;
    rd_item_t    it;
    bit          have;
    rv   = (p == 0) ? p0_rvalid : p1_rvalid;
    rd   = (p == 0) ? p0_rdata  : p1_rdata;
    have = (p == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (have) begin
      if (p == 0) it = q0[0];
      else        it = q1[0];
    end
    if (rv) begin
      if (!have) begin
        chk($sformatf("p%0d unexpected rvalid", p), rv, 0);
      end else begin
        pop(p);
        chk($sformatf("p%0d rdata", p), rd, it.data);
        chk($sformatf("p%0d rvalid cycle", p), cyc, it.due);
      end
    end else begin
      chk($sformatf("p%0d idle rdata", p), rd, 0);
      if (have && it.due <= cyc) begin
        chk($sformatf("p%0d missing rvalid", p), rv, 1);
        pop(p);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_l === 1'b1) begin
      mon(0);
      mon(1);
    end
  end

  task automatic drv0(input logic req, input logic we, input logic [5:0] a,
                      input logic [20:0] wd, input logic [20:0] wm);
    p0_req = req; p0_we = we; p0_addr = a; p0_wd = wd; p0_wmask = wm;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [5:0] a,
                      input logic [20:0] wd, input logic [20:0] wm);
    p1_req = req; p1_we = we; p1_addr = a; p1_wd = wd; p1_wmask = wm;
  endtask

  // Check grants mid-cycle; record expected effects of each grant.
  task automatic step(input string tag, input bit g0, input bit g1);
    rd_item_t it;
    @(negedge clk);
    chk({tag, " p0_gnt"}, p0_gnt, g0);
    chk({tag, " p1_gnt"}, p1_gnt, g1);
    if (g0) begin
      if (p0_we) ref_mem[p0_addr] = (p0_wd & p0_wmask) | (ref_mem[p0_addr] & ~p0_wmask);
      else begin it.data = ref_mem[p0_addr]; it.due = cyc + 1; q0.push_back(it); end
    end
    if (g1) begin
      if (p1_we) ref_mem[p1_addr] = (p1_wd & p1_wmask) | (ref_mem[p1_addr] & ~p1_wmask);
      else begin it.data = ref_mem[p1_addr]; it.due = cyc + 1; q1.push_back(it); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ram(input string tag, input logic ce, input logic we, input logic [5:0] a,
                         input logic [20:0] wd, input logic [20:0] wm);
    #1;
    chk({tag, " ram_ce"}, ram_ce, ce);
    chk({tag, " ram_we"}, ram_we, we);
    chk({tag, " ram_addr"}, ram_addr, a);
    chk({tag, " ram_wd"}, ram_wd, wd);
    chk({tag, " ram_wmask"}, ram_wmask, wm);
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk_ram(tag, 0, 0, 0, 0, 0);
    chk({tag, " p0_gnt"}, p0_gnt, 0);
    chk({tag, " p1_gnt"}, p1_gnt, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("init_done after reset", init_done, 1);
`ifdef FAKERAM45_64X21_ARB_INIT_EN
    for (int a = 0; a < 64; a++) ref_mem[a] = '0;
`endif
  endtask

  initial begin
    rst_l = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    drv0(1, 0, 6'h11, 0, 0);
    drv1(1, 0, 6'h22, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_ram("reset", 0, 0, 0, 0, 0);
    chk("reset p0_gnt", p0_gnt, 0);
    chk("reset p1_gnt", p1_gnt, 0);
    chk("reset p0_rvalid", p0_rvalid, 0);
    chk("reset p1_rvalid", p1_rvalid, 0);
    chk("reset p0_rdata", p0_rdata, 0);
    chk("reset p1_rdata", p1_rdata, 0);
`ifdef FAKERAM45_64X21_ARB_INIT_EN
    chk("reset init_done", init_done, 0);
`else
    chk("reset init_done", init_done, 1);
`endif
    @(posedge clk);
    #1 rst_l = 1'b1;

`ifdef FAKERAM45_64X21_ARB_INIT_EN
    begin : init_seq
      int i;
      bit restarted;
      i = 0;
      restarted = 1'b0;
      while (i < 64) begin
        @(negedge clk);
        chk_ram($sformatf("init %0d", i), 1, 1, 6'(i), 0, 21'h1FFFFF);
        chk("init p0_gnt", p0_gnt, 0);
        chk("init p1_gnt", p1_gnt, 0);
        chk("init init_done", init_done, 0);
        if (i == 30 && !restarted) begin
          #1 rst_l = 1'b0;
          restarted = 1'b1;
          @(posedge clk);
          #1;
          chk("init rst ram_ce", ram_ce, 0);
          chk("init rst init_done", init_done, 0);
          rst_l = 1'b1;
          i = 0;
        end else begin
          @(posedge clk);
          #1;
          i++;
        end
      end
      for (int a = 0; a < 64; a++) ref_mem[a] = '0;
    end
`endif

    // Continuous contention from reset: p0 first, then strict alternation.
    for (int k = 0; k < 6; k++) begin
      step("alt", (k % 2) == 0, (k % 2) == 1);
      if ((k % 2) == 0) p0_addr = p0_addr + 6'd3;
      else              p1_addr = p1_addr + 6'd5;
    end
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    chk_idle("idle a");
    chk_idle("idle b");

    drv0(1, 1, 6'd5, 21'h1ABCD, 21'h1FFFFF);
    chk_ram("wr5", 1, 1, 6'd5, 21'h1ABCD, 21'h1FFFFF);
    step("wr5", 1, 0);
    drv0(1, 0, 6'd5, 0, 0);
    step("rd5", 1, 0);
    drv0(0, 0, 0, 0, 0);
    chk_idle("after rd5");

    drv1(1, 1, 6'd9, 21'h000FF, 21'h1FFFFF);
    step("wr9 full", 0, 1);
    drv1(1, 1, 6'd9, 21'h1FF00, 21'h00F00);
    chk_ram("wr9 masked", 1, 1, 6'd9, 21'h1FF00, 21'h00F00);
    step("wr9 masked", 0, 1);
    drv1(1, 0, 6'd9, 0, 0);
    step("rd9", 0, 1);

    drv1(1, 1, 6'd20, 21'h15555, 21'h1FFFFF);
    step("wr20", 0, 1);
    drv1(0, 0, 0, 0, 0);
    drv0(1, 0, 6'd20, 0, 0);
    chk_ram("rd20", 1, 0, 6'd20, 0, 0);
    step("rd20 after wr", 1, 0);
    drv1(1, 0, 6'd9, 0, 0);
    step("rr p1 after p0", 0, 1);
    drv1(0, 0, 0, 0, 0);
    step("p0 alone", 1, 0);

    // Read granted, then reset lands mid-cycle before its data returns.
    drv0(1, 0, 6'd9, 0, 0);
    @(negedge clk);
    chk("rst-op p0_gnt", p0_gnt, 1);
    #1 rst_l = 1'b0;
    drv1(1, 0, 6'd20, 0, 0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    chk("rst-op p0_rvalid", p0_rvalid, 0);
    chk("rst-op p0_rdata", p0_rdata, 0);
    chk("rst-op p1_rvalid", p1_rvalid, 0);
    chk("rst-op p0_gnt", p0_gnt, 0);
    chk("rst-op p1_gnt", p1_gnt, 0);
    chk_ram("rst-op", 0, 0, 0, 0, 0);
    rst_l = 1'b1;
    wait_init();
    step("post-rst p0 first", 1, 0);
    step("post-rst p1 next", 0, 1);
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    chk_idle("tail a");
    chk_idle("tail b");
    chk("p0 queue drained", q0.size(), 0);
    chk("p1 queue drained", q1.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
